// File: rtl/button_debounce.sv
// button_debounce: synchronises and debounces two active-low buttons, emitting levels, press pulses and last direction
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic l_button,
  input  logic r_button,
  output logic l_level,
  output logic r_level,
  output logic l_press,
  output logic r_press,
  output logic dir
);
  typedef enum logic [1:0] {REL, PRESS_CHK, HELD, REL_CHK} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [1:0] ff1, s, level, press;
  state_t st [2];
  logic [CNT_W-1:0] cnt [2];
  // two-flop synchroniser per button; index 0 = left, 1 = right
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff1 <= 2'b11;
      s   <= 2'b11;
    end else begin
      ff1 <= {r_button, l_button};
      s   <= ff1;
    end
  end
  // per-button debounce FSM: a change is accepted only after DEBOUNCE_CYCLES stable samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= 2'b11;
      press <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        st[b]  <= REL;
        cnt[b] <= '0;
      end
    end else begin
      press <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        case (st[b])
          REL: if (!s[b]) begin
            st[b]  <= PRESS_CHK;
            cnt[b] <= CNT_W'(1);
          end
          PRESS_CHK: if (s[b]) begin
            st[b]  <= REL;
            cnt[b] <= '0;
          end else if (cnt[b] == LAST) begin
            st[b]    <= HELD;
            level[b] <= 1'b0;
            press[b] <= 1'b1;
            cnt[b]   <= '0;
          end else cnt[b] <= cnt[b] + 1'b1;
          HELD: if (s[b]) begin
            st[b]  <= REL_CHK;
            cnt[b] <= CNT_W'(1);
          end
          REL_CHK: if (!s[b]) begin
            st[b]  <= HELD;
            cnt[b] <= '0;
          end else if (cnt[b] == LAST) begin
            st[b]    <= REL;
            level[b] <= 1'b1;
            cnt[b]   <= '0;
          end else cnt[b] <= cnt[b] + 1'b1;
          default: begin
            st[b]  <= REL;
            cnt[b] <= '0;
          end
        endcase
      end
    end
  end
  // last direction: right press wins over a simultaneous left press
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dir <= 1'b0;
    else dir <= press[1] ? 1'b1 : press[0] ? 1'b0 : dir;
  end
  assign l_level = level[0];
  assign r_level = level[1];
  assign l_press = press[0];
  assign r_press = press[1];
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: scoreboard bench; stimulus queues expected output changes, a negedge monitor checks them
module tb_button_debounce;
  typedef struct {int cyc; logic [4:0] val;} ev_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic l_button = 1'b1;
  logic r_button = 1'b1;
  logic l_level, r_level, l_press, r_press, dir;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [4:0] obs, prev;
  ev_t it;
  ev_t q[$];
  button_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .l_button(l_button), .r_button(r_button),
    .l_level(l_level), .r_level(r_level), .l_press(l_press), .r_press(r_press), .dir(dir)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // monitor: every change of {l_level,r_level,l_press,r_press,dir} must match the next queued event
  always @(negedge clk) if (mon_en) begin
    obs = {l_level, r_level, l_press, r_press, dir};
    if (obs !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got=%b", cyc, obs);
      end else begin
        it = q.pop_front();
        if (it.cyc != cyc || it.val !== obs) begin
          errors++;
          $display("FAIL event cyc=%0d got=%b expected cyc=%0d val=%b", cyc, obs, it.cyc, it.val);
        end
      end
      prev = obs;
    end
  end
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic expect_ev(int k, logic [4:0] v);
    ev_t e;
    e.cyc = cyc + k;
    e.val = v;
    q.push_back(e);
  endtask
  task automatic check_now(string name, logic [4:0] exp);
    checks++;
    if ({l_level, r_level, l_press, r_press, dir} !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", name, {l_level, r_level, l_press, r_press, dir}, exp);
    end
  endtask
  initial begin
    step(3);
    #1 check_now("reset_values", 5'b11000);
    rst = 1'b1;
    prev = 5'b11000;
    mon_en = 1'b1;
    step(2);
    // clean left press, hold, release
    l_button = 1'b0; expect_ev(6, 5'b01100); expect_ev(7, 5'b01000); step(12);
    l_button = 1'b1; expect_ev(6, 5'b11000); step(10);
    // bounce rejection then a genuine press
    l_button = 1'b0; step(3); l_button = 1'b1; step(2); l_button = 1'b0; step(2); l_button = 1'b1; step(10);
    l_button = 1'b0; expect_ev(6, 5'b01100); expect_ev(7, 5'b01000); step(10);
    l_button = 1'b1; expect_ev(6, 5'b11000); step(10);
    // right press, release bounce while held, real release
    r_button = 1'b0; expect_ev(6, 5'b10010); expect_ev(7, 5'b10001); step(12);
    r_button = 1'b1; step(3); r_button = 1'b0; step(10);
    r_button = 1'b1; expect_ev(6, 5'b11001); step(10);
    // direction: left then right, then both together
    l_button = 1'b0; expect_ev(6, 5'b01101); expect_ev(7, 5'b01000); step(10);
    r_button = 1'b0; expect_ev(6, 5'b00010); expect_ev(7, 5'b00001); step(10);
    l_button = 1'b1; r_button = 1'b1; expect_ev(6, 5'b11001); step(10);
    l_button = 1'b0; r_button = 1'b0; expect_ev(6, 5'b00111); expect_ev(7, 5'b00001); step(10);
    l_button = 1'b1; r_button = 1'b1; expect_ev(6, 5'b11001); step(10);
    // asynchronous reset while left is held
    l_button = 1'b0; expect_ev(6, 5'b01101); expect_ev(7, 5'b01000); step(10);
    #2 rst = 1'b0;
    #1 check_now("async_reset", 5'b11000);
    expect_ev(1, 5'b11000);
    l_button = 1'b1; r_button = 1'b0; step(3);
    // right held through reset release
    #2 rst = 1'b1;
    expect_ev(6, 5'b10010); expect_ev(7, 5'b10001); step(12);
    r_button = 1'b1; expect_ev(6, 5'b11001); step(10);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
